// File: rtl/gsu_icache.sv
// GSU instruction cache: configurable line count and size, autonomous ROM line fill,
// an uncached bypass for fetches outside the window, and a host port into the cache RAM.
module gsu_icache #(
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned LINES      = 32,
    parameter int unsigned OFS_W      = $clog2(LINES * LINE_BYTES)
) (
    input  logic             clkin_i,
    input  logic             rst_i,
    input  logic             cbr_set_i,
    input  logic [15:0]      cbr_in_i,
    input  logic             flush_i,
    output logic [15:0]      cbr_o,
    input  logic             fetch_req_i,
    input  logic [15:0]      fetch_pc_i,
    input  logic [7:0]       fetch_bank_i,
    output logic             fetch_busy_o,
    output logic             fetch_ack_o,
    output logic [7:0]       fetch_data_o,
    output logic             rom_req_o,
    output logic [23:0]      rom_addr_o,
    input  logic             rom_ack_i,
    input  logic [7:0]       rom_data_i,
    input  logic             host_we_i,
    input  logic             host_re_i,
    input  logic [OFS_W-1:0] host_ofs_i,
    input  logic [7:0]       host_wdata_i,
    output logic [7:0]       host_rdata_o
);
    localparam int unsigned CSZ  = LINES * LINE_BYTES;
    localparam int unsigned LB_W = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        StIdle, StHit, StFill, StFillGap, StBypass, StResp
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cbr_q, cbr_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [7:0]         bank_q, bank_d;
    logic [15:0]        addr_q, addr_d;
    logic [OFS_W-1:0]   off_q, off_d;
    logic [LB_W-1:0]    k_q, k_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         host_rdata_q, host_rdata_d;
    logic               pend_cbr_q, pend_cbr_d;
    logic               pend_clr_q, pend_clr_d;
    logic [15:0]        pend_val_q, pend_val_d;

    logic [7:0]         ram_q [CSZ];
    logic               ram_we;
    logic [OFS_W-1:0]   ram_waddr;
    logic [7:0]         ram_wdata;

    logic [15:0]        fetch_off;
    logic               in_range;
    logic [15:0]        line_base;
    logic               idle_free;
    logic               ctrl_any;

    // Offset wraps modulo 2^16, so a window near $FFFF continues at $0000.
    assign fetch_off = fetch_pc_i - cbr_q;
    assign in_range  = {1'b0, fetch_off} < 17'(CSZ);
    assign line_base = cbr_q + (fetch_off & ~16'(LINE_BYTES - 1));
    assign idle_free = (state_q == StIdle) && !fetch_req_i;
    assign ctrl_any  = cbr_set_i | flush_i;

    always_comb begin
        state_d      = state_q;
        cbr_d        = cbr_q;
        valid_d      = valid_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        off_d        = off_q;
        k_d          = k_q;
        data_d       = data_q;
        host_rdata_d = host_rdata_q;
        pend_cbr_d   = pend_cbr_q;
        pend_clr_d   = pend_clr_q;
        pend_val_d   = pend_val_q;
        ram_we       = 1'b0;
        ram_waddr    = '0;
        ram_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                if (fetch_req_i) begin
                    bank_d = fetch_bank_i;
                    off_d  = fetch_off[OFS_W-1:0];
                    k_d    = '0;
                    if (!in_range) begin
                        addr_d  = fetch_pc_i;
                        state_d = StBypass;
                    end else if (valid_q[fetch_off[OFS_W-1:LB_W]]) begin
                        state_d = StHit;
                    end else begin
                        addr_d  = line_base;
                        state_d = StFill;
                    end
                end
            end
            StHit: begin
                data_d  = ram_q[off_q];
                state_d = StResp;
            end
            StFill: begin
                if (rom_ack_i) begin
                    ram_we    = 1'b1;
                    ram_waddr = {off_q[OFS_W-1:LB_W], k_q};
                    ram_wdata = rom_data_i;
                    if (k_q == off_q[LB_W-1:0]) begin
                        data_d = rom_data_i;
                    end
                    if (&k_q) begin
                        valid_d[off_q[OFS_W-1:LB_W]] = 1'b1;
                        state_d = StResp;
                    end else begin
                        k_d     = k_q + 1'b1;
                        addr_d  = addr_q + 16'd1;
                        state_d = StFillGap;
                    end
                end
            end
            StFillGap: state_d = StFill;
            StBypass: begin
                if (rom_ack_i) begin
                    data_d  = rom_data_i;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (idle_free && host_we_i) begin
            ram_we    = 1'b1;
            ram_waddr = host_ofs_i;
            ram_wdata = host_wdata_i;
            if (&host_ofs_i[LB_W-1:0]) begin
                valid_d[host_ofs_i[OFS_W-1:LB_W]] = 1'b1;
            end
        end
        if (host_re_i) begin
            host_rdata_d = idle_free ? ram_q[host_ofs_i] : 8'hFF;
        end

        // Control arriving while busy (or alongside a fetch) waits for the return to idle.
        if (idle_free) begin
            if (cbr_set_i) cbr_d = {cbr_in_i[15:4], 4'h0};
            if (ctrl_any) valid_d = '0;
        end else begin
            if (ctrl_any) pend_clr_d = 1'b1;
            if (cbr_set_i) begin
                pend_cbr_d = 1'b1;
                pend_val_d = {cbr_in_i[15:4], 4'h0};
            end
        end
        if (state_q == StResp) begin
            if (pend_cbr_d) cbr_d = pend_val_d;
            if (pend_clr_d) valid_d = '0;
            pend_cbr_d = 1'b0;
            pend_clr_d = 1'b0;
        end
    end

    always_ff @(posedge clkin_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cbr_q        <= '0;
            valid_q      <= '0;
            bank_q       <= '0;
            addr_q       <= '0;
            off_q        <= '0;
            k_q          <= '0;
            data_q       <= '0;
            host_rdata_q <= '0;
            pend_cbr_q   <= 1'b0;
            pend_clr_q   <= 1'b0;
            pend_val_q   <= '0;
        end else begin
            state_q      <= state_d;
            cbr_q        <= cbr_d;
            valid_q      <= valid_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            k_q          <= k_d;
            data_q       <= data_d;
            host_rdata_q <= host_rdata_d;
            pend_cbr_q   <= pend_cbr_d;
            pend_clr_q   <= pend_clr_d;
            pend_val_q   <= pend_val_d;
        end
    end

    always_ff @(posedge clkin_i) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign cbr_o        = cbr_q;
    assign fetch_busy_o = (state_q != StIdle);
    assign fetch_ack_o  = (state_q == StResp);
    assign fetch_data_o = data_q;
    assign rom_req_o    = (state_q == StFill) || (state_q == StBypass);
    assign rom_addr_o   = {bank_q, addr_q};
    assign host_rdata_o = host_rdata_q;

endmodule

// File: tb/tb_gsu_icache.sv
// Randomised bench for gsu_icache against a byte-array cache model and a 2-cycle ROM responder.
module tb_gsu_icache;
    localparam int LB    = 16;
    localparam int NL    = 32;
    localparam int CSZ   = LB * NL;
    localparam int OFS_W = $clog2(CSZ);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cbr_set = 1'b0, flush = 1'b0;
    logic [15:0]      cbr_in = '0, cbr;
    logic             fetch_req = 1'b0;
    logic [15:0]      fetch_pc = '0;
    logic [7:0]       fetch_bank = '0;
    logic             fetch_busy, fetch_ack;
    logic [7:0]       fetch_data;
    logic             rom_req;
    logic [23:0]      rom_addr;
    logic             rom_ack = 1'b0;
    logic [7:0]       rom_data = '0;
    logic             host_we = 1'b0, host_re = 1'b0;
    logic [OFS_W-1:0] host_ofs = '0;
    logic [7:0]       host_wdata = '0, host_rdata;

    gsu_icache #(.LINE_BYTES(LB), .LINES(NL)) dut (
        .clkin_i(clk), .rst_i(rst), .cbr_set_i(cbr_set), .cbr_in_i(cbr_in), .flush_i(flush),
        .cbr_o(cbr), .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc), .fetch_bank_i(fetch_bank),
        .fetch_busy_o(fetch_busy), .fetch_ack_o(fetch_ack), .fetch_data_o(fetch_data),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_ack_i(rom_ack), .rom_data_i(rom_data),
        .host_we_i(host_we), .host_re_i(host_re), .host_ofs_i(host_ofs),
        .host_wdata_i(host_wdata), .host_rdata_o(host_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0, errors = 0;
    logic [7:0]  m_ram [CSZ];
    bit          m_valid [NL];
    logic [15:0] m_cbr;
    logic [23:0] exp_q [$];
    int          last_ack_cyc = 0;
    logic [23:0] first_addr = '0;
    bit          first_seen = 1'b0;
    logic [7:0]  last_data = '0;
    bit          in_rst_test = 1'b0;

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_valid();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // ROM arbiter model: 2-cycle latency, checks address order, stability and the gap cycle.
    initial begin
        int w;
        logic [23:0] la;
        w  = -1;
        la = '0;
        forever begin
            @(posedge clk);
            #1;
            rom_ack = 1'b0;
            if (w > 0) begin
                if (!in_rst_test) begin
                    check("rom_req_hold", rom_req, 1);
                    check("rom_addr_stable", rom_addr, la);
                end
                w--;
            end else if (w == 0) begin
                rom_ack      = 1'b1;
                rom_data     = rom_byte(la);
                last_ack_cyc = cyc;
                w            = -2;
            end else if (w == -2) begin
                if (!in_rst_test) check("rom_gap", rom_req, 0);
                w = -1;
            end else if (rom_req) begin
                if (exp_q.size() == 0) check("rom_req_unexpected", rom_req, 0);
                else check("rom_addr", rom_addr, exp_q.pop_front());
                if (!first_seen) begin
                    first_addr = rom_addr;
                    first_seen = 1'b1;
                end
                la = rom_addr;
                w  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (fetch_ack) check("ack_implies_busy", fetch_busy, 1);
        if (rom_req) check("req_implies_busy", fetch_busy, 1);
    end

    // mode: 0 plain, 1 cbr_set with fetch_req, 2 cbr_set in flight, 3 flush in flight,
    // 4 host write+read in flight (dropped).
    task automatic do_fetch(input logic [15:0] pc, input logic [7:0] bank, input int mode,
                            input logic [15:0] cval);
        logic [15:0] off, base;
        int          line, t0;
        bit          inr, hit, acked;
        logic [7:0]  expd;
        off  = pc - m_cbr;
        inr  = off < CSZ;
        line = int'(off) / LB;
        hit  = inr && m_valid[line];
        base = m_cbr + 16'(line * LB);
        if (!inr) exp_q.push_back({bank, pc});
        else if (!hit) for (int k = 0; k < LB; k++) exp_q.push_back({bank, 16'(base + k)});
        expd       = hit ? m_ram[off] : rom_byte({bank, pc});
        first_seen = 1'b0;
        fetch_req  = 1'b1;
        fetch_pc   = pc;
        fetch_bank = bank;
        if (mode == 1) begin
            cbr_set = 1'b1;
            cbr_in  = cval;
        end
        t0 = cyc;
        @(posedge clk);
        #1;
        fetch_req  = 1'b0;
        cbr_set    = 1'b0;
        fetch_pc   = 16'($urandom);
        fetch_bank = 8'($urandom);
        if (!hit) check("rom_req_rise", rom_req, 1);
        if (mode == 2) begin
            cbr_set = 1'b1;
            cbr_in  = cval;
        end
        if (mode == 3) flush = 1'b1;
        if (mode == 4) begin
            host_we    = 1'b1;
            host_re    = 1'b1;
            host_ofs   = cval[OFS_W-1:0];
            host_wdata = ~m_ram[cval[OFS_W-1:0]];
        end
        acked = 1'b0;
        for (int i = 0; i < 400 && !acked; i++) begin
            check("busy", fetch_busy, 1);
            check("cbr_hold", cbr, m_cbr);
            if (i == 1 && mode == 4) check("host_drop_rdata", host_rdata, 8'hFF);
            if (fetch_ack) begin
                acked     = 1'b1;
                last_data = fetch_data;
                check("fetch_data", fetch_data, expd);
                if (hit) check("hit_latency", cyc - t0, 2);
                else check("miss_latency", cyc - last_ack_cyc, 1);
                check("rom_reqs_done", exp_q.size(), 0);
            end else begin
                @(posedge clk);
                #1;
                cbr_set = 1'b0;
                flush   = 1'b0;
                host_we = 1'b0;
                host_re = 1'b0;
            end
        end
        if (!acked) begin
            check("fetch_ack_timeout", fetch_ack, 1);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check("ack_pulse", fetch_ack, 0);
        check("busy_end", fetch_busy, 0);
        if (inr && !hit) begin
            for (int k = 0; k < LB; k++) m_ram[line * LB + k] = rom_byte({bank, 16'(base + k)});
            m_valid[line] = 1'b1;
        end
        if (mode == 1 || mode == 2) begin
            m_cbr = cval & 16'hFFF0;
            clear_valid();
        end
        if (mode == 3) clear_valid();
        check("cbr_after", cbr, m_cbr);
    endtask

    task automatic host_write(input int ofs, input logic [7:0] d);
        host_we    = 1'b1;
        host_ofs   = OFS_W'(ofs);
        host_wdata = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
        m_ram[ofs] = d;
        if (ofs % LB == LB - 1) m_valid[ofs / LB] = 1'b1;
    endtask

    task automatic host_read(input int ofs);
        host_re  = 1'b1;
        host_ofs = OFS_W'(ofs);
        @(posedge clk);
        #1;
        host_re = 1'b0;
        check("host_rdata", host_rdata, m_ram[ofs]);
    endtask

    task automatic ctl(input bit set, input bit fl, input logic [15:0] v);
        cbr_set = set;
        flush   = fl;
        cbr_in  = v;
        @(posedge clk);
        #1;
        cbr_set = 1'b0;
        flush   = 1'b0;
        if (set) m_cbr = v & 16'hFFF0;
        clear_valid();
        check("cbr_ctl", cbr, m_cbr);
    endtask

    initial begin
        int op;
        logic [15:0] pc, cv;
        m_cbr = '0;
        clear_valid();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cbr", cbr, 0);
        check("rst_ack", fetch_ack, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_rom_req", rom_req, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_fetch_data", fetch_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset during a fill: request must drop at once, the late ROM ack is ignored.
        ctl(1'b1, 1'b0, 16'h0100);
        in_rst_test = 1'b1;
        for (int k = 0; k < LB; k++) exp_q.push_back({8'h00, 16'(16'h0100 + k)});
        fetch_req = 1'b1;
        fetch_pc  = 16'h0100;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_rom_req", rom_req, 0);
        check("rst_mid_ack", fetch_ack, 0);
        check("rst_mid_busy", fetch_busy, 0);
        check("rst_mid_cbr", cbr, 0);
        m_cbr = '0;
        clear_valid();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        in_rst_test = 1'b0;
        check("post_rst_idle", fetch_busy, 0);
        do_fetch(16'h0000, 8'h00, 0, 16'h0);
        check("lit_post_rst_first_addr", first_addr, 24'h000000);

        for (int o = 0; o < CSZ; o++) host_write(o, 8'($urandom));
        for (int i = 0; i < 6; i++) host_read(int'($urandom_range(0, CSZ - 1)));
        ctl(1'b0, 1'b1, 16'h0);

        // Host preload then hit.
        ctl(1'b1, 1'b0, 16'h8000);
        for (int o = 16'h10; o <= 16'h1F; o++) host_write(o, 8'hA5);
        do_fetch(16'h8013, 8'h00, 0, 16'h0);
        check("lit_preload_data", last_data, 8'hA5);

        // Miss fill then re-fetch hit.
        ctl(1'b1, 1'b0, 16'h0100);
        do_fetch(16'h0123, 8'h00, 0, 16'h0);
        check("lit_fill_first_addr", first_addr, 24'h000120);
        check("lit_fill_data", last_data, 8'h23);
        do_fetch(16'h0125, 8'h00, 0, 16'h0);
        check("lit_refetch_data", last_data, 8'h25);

        // Bypass outside the window.
        ctl(1'b1, 1'b0, 16'h0000);
        do_fetch(16'h0400, 8'h01, 0, 16'h0);
        check("lit_bypass_addr", first_addr, 24'h010400);
        check("lit_bypass_data", last_data, 8'h01);

        // Window wrapping past $FFFF.
        ctl(1'b1, 1'b0, 16'hFFF0);
        do_fetch(16'h0005, 8'h00, 0, 16'h0);
        check("lit_wrap_addr", first_addr, 24'h000000);
        check("lit_wrap_data", last_data, 8'h05);

        // Deferred control.
        ctl(1'b1, 1'b0, 16'h0100);
        do_fetch(16'h0140, 8'h00, 2, 16'h2000);
        check("lit_pending_cbr", cbr, 16'h2000);
        do_fetch(16'h2000, 8'h00, 0, 16'h0);
        do_fetch(16'h2000, 8'h00, 1, 16'h3007);
        check("lit_same_cycle_cbr", cbr, 16'h3000);
        do_fetch(16'h3001, 8'h02, 3, 16'h0);
        do_fetch(16'h3050, 8'h00, 4, 16'h0055);
        host_read(16'h0055);
        ctl(1'b1, 1'b1, 16'h4567);
        check("lit_set_and_flush", cbr, 16'h4560);

        for (int it = 0; it < 200; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                pc = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                 : 16'(m_cbr + $urandom_range(0, CSZ + 31));
                cv = 16'($urandom);
                do_fetch(pc, 8'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, cv);
            end else if (op <= 6) begin
                host_write(int'($urandom_range(0, CSZ - 1)), 8'($urandom));
            end else if (op == 7) begin
                host_read(int'($urandom_range(0, CSZ - 1)));
            end else if (op == 8) begin
                ctl(1'b0, 1'b1, 16'h0);
            end else begin
                case ($urandom_range(0, 3))
                    0: cv = 16'h0000;
                    1: cv = 16'h0100;
                    2: cv = 16'hFFF0;
                    default: cv = 16'h8000;
                endcase
                ctl(1'b1, 1'b0, cv);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
